// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyD
  } arb_state_t;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and load/store access,
// one transaction at a time, with a per-transfer acknowledge timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ifReq,
  input  logic [XLEN-1:0] i_ifAddr,
  input  logic            i_dReq,
  input  logic            i_dWrite,
  input  logic [1:0]      i_dSize,
  input  logic [XLEN-1:0] i_dAddr,
  input  logic [XLEN-1:0] i_dWdata,
  output logic            o_memReq,
  output logic            o_memWrite,
  output logic [1:0]      o_memSize,
  output logic [XLEN-1:0] o_memAddr,
  output logic [XLEN-1:0] o_memWdata,
  input  logic            i_memAck,
  input  logic [XLEN-1:0] i_memRdata,
  output logic            o_ifValid,
  output logic [XLEN-1:0] o_ifRdata,
  output logic            o_dValid,
  output logic [XLEN-1:0] o_dRdata,
  output logic            o_stall,
  output logic            o_busErr
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_write_q, mem_write_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            d_valid_q, d_valid_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            bus_err_q, bus_err_d;
  logic            if_req_eff, d_req_eff;

  // A requester still holds its request during its completion pulse; do not regrant it then.
  assign if_req_eff = i_ifReq & ~if_valid_q;
  assign d_req_eff  = i_dReq & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (d_req_eff) begin
          if (i_dSize == SIZE_BAD) begin
            d_valid_d = 1'b1;
            bus_err_d = 1'b1;
          end else begin
            state_d     = StBusyD;
            mem_req_d   = 1'b1;
            mem_write_d = i_dWrite;
            mem_size_d  = i_dSize;
            mem_addr_d  = i_dAddr;
            mem_wdata_d = i_dWdata;
          end
        end else if (if_req_eff) begin
          state_d     = StBusyIf;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_size_d  = SIZE_W;
          mem_addr_d  = i_ifAddr;
        end
      end
      StBusyIf, StBusyD: begin
        if (i_memAck) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == StBusyIf) begin
            if_valid_d = 1'b1;
            if_rdata_d = i_memRdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_write_q) d_rdata_d = i_memRdata;
          end
        end else if (cnt_q == CntLast) begin
          // Last allowed cycle passed with no ack: abort, leave read data untouched.
          state_d   = StIdle;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          if (state_q == StBusyIf) if_valid_d = 1'b1;
          else                     d_valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_memReq   = mem_req_q;
  assign o_memWrite = mem_write_q;
  assign o_memSize  = mem_size_q;
  assign o_memAddr  = mem_addr_q;
  assign o_memWdata = mem_wdata_q;
  assign o_ifValid  = if_valid_q;
  assign o_ifRdata  = if_rdata_q;
  assign o_dValid   = d_valid_q;
  assign o_dRdata   = d_rdata_q;
  assign o_busErr   = bus_err_q;
  assign o_stall    = if_req_eff | d_req_eff;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected completions, a memory
// responder with address-derived latency/data answers the bus, a monitor pops and compares.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        write;
    logic [1:0]  size;
    logic        err;
    logic        bus;
    int          hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i_ifReq, i_dReq, i_dWrite, i_memAck;
  logic [1:0] i_dSize;
  logic [31:0] i_ifAddr, i_dAddr, i_dWdata, i_memRdata;
  logic o_memReq, o_memWrite, o_ifValid, o_dValid, o_stall, o_busErr;
  logic [1:0] o_memSize;
  logic [31:0] o_memAddr, o_memWdata, o_ifRdata, o_dRdata;

  int checks = 0;
  int errors = 0;
  exp_t if_q[$];
  exp_t d_q[$];
  logic [31:0] mdl_if_rdata = '0;
  logic [31:0] mdl_d_rdata = '0;

  // responder / monitor state
  int cyc = 0;
  int cnt = 0;
  int hi_cnt = 0;
  int cap_start = 0;
  int last_if_start = 0, last_d_start = 0, last_if_vcyc = 0, last_d_vcyc = 0;
  logic ended_now;
  logic [31:0] cap_addr, cap_wdata;
  logic cap_write;
  logic [1:0] cap_size;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr),
    .i_dReq(i_dReq), .i_dWrite(i_dWrite), .i_dSize(i_dSize), .i_dAddr(i_dAddr),
    .i_dWdata(i_dWdata),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memSize(o_memSize),
    .o_memAddr(o_memAddr), .o_memWdata(o_memWdata),
    .i_memAck(i_memAck), .i_memRdata(i_memRdata),
    .o_ifValid(o_ifValid), .o_ifRdata(o_ifRdata),
    .o_dValid(o_dValid), .o_dRdata(o_dRdata),
    .o_stall(o_stall), .o_busErr(o_busErr)
  );

  // Memory behaviour is a pure function of the address, so expectations are known at issue.
  function automatic int lat_of(input logic [31:0] a);
    return int'(((a >> 2) ^ (a >> 7)) % 32'd20) + 1;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] find_addr(input int lo, input int hi);
    for (int k = 0; k < 4096; k++) begin
      logic [31:0] a;
      a = 32'h4000 + 32'(k) * 4;
      if (lat_of(a) >= lo && lat_of(a) <= hi) return a;
    end
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_entry(input exp_t e, input logic is_if);
    string p;
    p = is_if ? "if" : "d";
    check({p, "_rdata"}, is_if ? o_ifRdata : o_dRdata, e.rdata);
    check({p, "_buserr"}, 32'(o_busErr), 32'(e.err));
    check({p, "_bus_used"}, 32'(ended_now), 32'(e.bus));
    if (e.bus && ended_now) begin
      check({p, "_addr"}, cap_addr, e.addr);
      check({p, "_write"}, 32'(cap_write), 32'(e.write));
      check({p, "_size"}, 32'(cap_size), 32'(e.size));
      if (e.write) check({p, "_wdata"}, cap_wdata, e.wdata);
      check({p, "_req_cycles"}, 32'(hi_cnt), 32'(e.hi));
    end
  endtask

  // Memory responder followed by scoreboard monitor, both on the falling edge.
  initial begin
    i_memAck = 1'b0;
    i_memRdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ended_now = 1'b0;
      if (rst) begin
        cnt = 0;
        i_memAck = 1'b0;
      end else begin
        if (o_memReq) begin
          if (cnt == 0) begin
            cap_addr = o_memAddr; cap_wdata = o_memWdata;
            cap_write = o_memWrite; cap_size = o_memSize; cap_start = cyc;
          end else if (o_memAddr !== cap_addr || o_memWrite !== cap_write ||
                       o_memSize !== cap_size || o_memWdata !== cap_wdata) begin
            check("bus_stable", o_memAddr, cap_addr);
          end
          cnt++;
          i_memAck = (cnt == lat_of(cap_addr));
          i_memRdata = i_memAck ? data_of(cap_addr) : $urandom;
        end else begin
          if (cnt > 0) begin
            hi_cnt = cnt;
            ended_now = 1'b1;
            cnt = 0;
          end
          // Stray acks while idle must be ignored.
          i_memAck = ($urandom_range(0, 5) == 0);
          i_memRdata = $urandom;
        end

        check("stall", 32'(o_stall), 32'((i_ifReq & ~o_ifValid) | (i_dReq & ~o_dValid)));
        if (o_ifValid) begin
          last_if_vcyc = cyc;
          if (ended_now) last_if_start = cap_start;
          if (if_q.size() == 0) check("if_unexpected_valid", 32'(o_ifValid), 32'h0);
          else check_entry(if_q.pop_front(), 1'b1);
        end
        if (o_dValid) begin
          last_d_vcyc = cyc;
          if (ended_now) last_d_start = cap_start;
          if (d_q.size() == 0) check("d_unexpected_valid", 32'(o_dValid), 32'h0);
          else check_entry(d_q.pop_front(), 1'b0);
        end
        if (o_busErr && !o_ifValid && !o_dValid) check("buserr_alone", 32'(o_busErr), 32'h0);
      end
    end
  end

  task automatic if_issue(input logic [31:0] a);
    exp_t e;
    logic got;
    i_ifReq = 1'b1;
    i_ifAddr = a;
    e.addr = a; e.wdata = '0; e.write = 1'b0; e.size = SIZE_W; e.bus = 1'b1;
    e.err = lat_of(a) > TIMEOUT;
    e.hi = e.err ? TIMEOUT : lat_of(a);
    e.rdata = e.err ? mdl_if_rdata : data_of(a);
    mdl_if_rdata = e.rdata;
    if_q.push_back(e);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = o_ifValid;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL if_valid_wait actual=none required=pulse addr=%h", a);
    end
    @(posedge clk); #1;
    i_ifReq = 1'b0;
  endtask

  task automatic d_issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    exp_t e;
    logic got, bad;
    i_dReq = 1'b1; i_dWrite = w; i_dSize = sz; i_dAddr = a; i_dWdata = wd;
    bad = (sz == 2'b11);
    e.addr = a; e.wdata = wd; e.write = w; e.size = sz; e.bus = !bad;
    e.err = bad || lat_of(a) > TIMEOUT;
    e.hi = (lat_of(a) > TIMEOUT) ? TIMEOUT : lat_of(a);
    e.rdata = (!e.err && !w) ? data_of(a) : mdl_d_rdata;
    mdl_d_rdata = e.rdata;
    d_q.push_back(e);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = o_dValid;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_valid_wait actual=none required=pulse addr=%h", a);
    end
    @(posedge clk); #1;
    i_dReq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int issue_cyc;
    logic [31:0] a;
    rst = 1'b1;
    i_ifReq = 1'b1; i_ifAddr = 32'h100;
    i_dReq = 1'b0; i_dWrite = 1'b0; i_dSize = SIZE_W; i_dAddr = '0; i_dWdata = '0;

    // Reset with a fetch pending: everything stays quiet.
    repeat (2) begin
      @(negedge clk);
      check("rst_memreq", 32'(o_memReq), 32'h0);
      check("rst_valids", {30'h0, o_ifValid, o_dValid}, 32'h0);
      check("rst_buserr", 32'(o_busErr), 32'h0);
      check("rst_ifrdata", o_ifRdata, 32'h0);
      check("rst_drdata", o_dRdata, 32'h0);
      check("rst_memaddr", o_memAddr, 32'h0);
    end
    @(posedge clk); #1;
    i_ifReq = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch, then a byte store.
    if_issue(32'h100);
    check("fetch_word", o_ifRdata, 32'h0050_0093);
    d_issue(1'b1, SIZE_B, 32'h2003, 32'hAB);

    // Contention: data first, fetch one idle cycle after the data completion.
    issue_cyc = cyc;
    fork
      if_issue(32'h100);
      d_issue(1'b0, SIZE_W, 32'h2000, 32'h0);
    join
    check("contention_d_start", 32'(last_d_start), 32'(issue_cyc + 2));
    check("contention_if_after_d", 32'(last_if_start), 32'(last_d_vcyc + 1));

    // Timeout abort, and ack on the last allowed cycle.
    d_issue(1'b0, SIZE_W, find_addr(TIMEOUT + 1, 20), 32'h0);
    if_issue(find_addr(TIMEOUT + 1, 20));
    d_issue(1'b0, SIZE_W, find_addr(TIMEOUT, TIMEOUT), 32'h0);
    d_issue(1'b1, SIZE_H, find_addr(TIMEOUT + 1, 20), 32'h5A5A);

    // Illegal size: no bus cycle, error plus valid.
    d_issue(1'b0, SIZE_BAD, 32'h3000, 32'h0);

    // Randomized concurrent traffic.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if_issue($urandom);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          d_issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? SIZE_BAD : 2'($urandom_range(0, 2)),
                  $urandom, $urandom);
        end
      end
    join

    // Reset in the middle of a transfer: it is dropped with no completion.
    a = find_addr(TIMEOUT + 1, 20);
    i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = SIZE_W; i_dAddr = a;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_busy", 32'(o_memReq), 32'h1);
    rst = 1'b1;
    i_dReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_d_rdata = '0;
    mdl_if_rdata = '0;
    repeat (20) begin
      @(negedge clk);
      if (o_memReq || o_dValid || o_busErr)
        check("midrst_quiet", {29'h0, o_memReq, o_dValid, o_busErr}, 32'h0);
    end
    check("midrst_memreq", 32'(o_memReq), 32'h0);
    check("midrst_drdata", o_dRdata, 32'h0);
    @(posedge clk); #1;
    d_issue(1'b0, SIZE_W, 32'h2000, 32'h0);

    repeat (3) @(negedge clk);
    check("if_queue_empty", 32'(if_q.size()), 32'h0);
    check("d_queue_empty", 32'(d_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
